// File: rtl/line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// line_mem_arbiter
//
// Memory-side responder for the two pipeline line ports (instruction fetch and
// data). Both ports present level-held requests. A request is accepted only
// while the arbiter is idle. It is then run as a single transaction on a shared
// line-wide cyc/stb/we/ack bus. The port gets back registered line data and a
// one-cycle resp pulse.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   ifetch_read          instruction line read request (held until ifetch_resp)
//   ifetch_address       instruction line address
//   ifetch_rdata         instruction line data, valid with/after ifetch_resp
//   ifetch_resp          one-cycle completion pulse, instruction port
//   mem_read, mem_write  data line read/write requests (held until mem_resp)
//   mem_address          data line address
//   mem_wdata, mem_sel   write data and byte enables (sel ignored on reads)
//   mem_rdata            data line read data, valid with/after mem_resp
//   mem_resp             one-cycle completion pulse, data port
//   bus_cyc, bus_stb     bus transaction active (identical)
//   bus_we, bus_adr      write strobe and line address
//   bus_sel, bus_dat_w   byte enables (all ones on reads) and write data
//   bus_dat_r, bus_ack   read data and completion (ack may come with first stb)
//
// Timing
//   A request is sampled in IDLE at cycle 0. Strobe is high in cycles 1..1+k,
//   with ack arriving at 1+k. The resp pulse occurs at cycle 2+k. The arbiter
//   is idle again at cycle 3+k.
// -----------------------------------------------------------------------------
module line_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int LINE_W = 128,
    parameter int SEL_W  = LINE_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifetch_read,
    input  logic [ADDR_W-1:0] ifetch_address,
    output logic [LINE_W-1:0] ifetch_rdata,
    output logic              ifetch_resp,

    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,

    output logic              bus_cyc,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_adr,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [LINE_W-1:0] bus_dat_w,
    input  logic [LINE_W-1:0] bus_dat_r,
    input  logic              bus_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUS_I  = 3'd1,
        BUS_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    state_t next_state;
    logic   last_grant;

    logic ireq;
    logic dreq;
    logic grant_i;
    logic grant_d;

    assign ireq = ifetch_read;
    assign dreq = mem_read | mem_write;

    // Round robin applies only on a tie. A lone request is always granted,
    // whichever port was served last.
    assign grant_i = (state == IDLE) && ireq && (!dreq || (last_grant == GRANT_D));
    assign grant_d = (state == IDLE) && dreq && (!ireq || (last_grant == GRANT_I));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_i)      next_state = BUS_I;
                else if (grant_d) next_state = BUS_D;
            end
            BUS_I:   if (bus_ack) next_state = RESP_I;
            BUS_D:   if (bus_ack) next_state = RESP_D;
            // Requests are deliberately not sampled here. This gives the
            // requester the resp cycle to drop or retarget its request.
            RESP_I:  next_state = IDLE;
            RESP_D:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from state. Because cyc/stb follow the BUS states
    // directly, a reset mid-transaction drops them at that same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        bus_cyc     = 1'b0;
        bus_stb     = 1'b0;
        ifetch_resp = 1'b0;
        mem_resp    = 1'b0;
        unique case (state)
            BUS_I, BUS_D: begin
                bus_cyc = 1'b1;
                bus_stb = 1'b1;
            end
            RESP_I:  ifetch_resp = 1'b1;
            RESP_D:  mem_resp    = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus request registers: loaded only on a grant, so they stay stable for
    // the whole strobe window regardless of what the requester does.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we     <= 1'b0;
            bus_adr    <= '0;
            bus_sel    <= '0;
            bus_dat_w  <= '0;
            last_grant <= GRANT_D;
        end else if (grant_i) begin
            bus_we     <= 1'b0;
            bus_adr    <= ifetch_address;
            bus_sel    <= '1;
            bus_dat_w  <= '0;
            last_grant <= GRANT_I;
        end else if (grant_d) begin
            // If read and write are both asserted, the request is treated as a write.
            bus_we     <= mem_write;
            bus_adr    <= mem_address;
            bus_sel    <= mem_write ? mem_sel : '1;
            bus_dat_w  <= mem_write ? mem_wdata : '0;
            last_grant <= GRANT_D;
        end
    end

    // -------------------------------------------------------------------------
    // Read data return. Capture happens only on an ack in the matching BUS
    // state, so stray acks are ignored. A write leaves mem_rdata untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifetch_rdata <= '0;
            mem_rdata    <= '0;
        end else begin
            if ((state == BUS_I) && bus_ack)
                ifetch_rdata <= bus_dat_r;
            if ((state == BUS_D) && bus_ack && !bus_we)
                mem_rdata <= bus_dat_r;
        end
    end

endmodule

// File: tb/tb_line_mem_arbiter.sv
module tb_line_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int LINE_W = 128;
    localparam int SEL_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ifetch_read;
    logic [ADDR_W-1:0] ifetch_address;
    logic [LINE_W-1:0] ifetch_rdata;
    logic              ifetch_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [SEL_W-1:0]  mem_sel;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              bus_cyc;
    logic              bus_stb;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_adr;
    logic [SEL_W-1:0]  bus_sel;
    logic [LINE_W-1:0] bus_dat_w;
    logic [LINE_W-1:0] bus_dat_r;
    logic              bus_ack;

    int n_cmp = 0;
    int n_err = 0;

    line_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
        .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
        .bus_sel(bus_sel), .bus_dat_w(bus_dat_w), .bus_dat_r(bus_dat_r),
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven. Acks after k+1
    // strobe cycles, checks the resp cycle, and returns in the following cycle.
    task automatic txn(input string tag, input int k, input bit exp_i,
                       input logic [ADDR_W-1:0] adr, input bit we,
                       input logic [SEL_W-1:0] sel, input logic [LINE_W-1:0] datw,
                       input logic [LINE_W-1:0] datr, input logic [LINE_W-1:0] exp_rdata);
        @(negedge clk);
        chk1({tag, " idle cyc"}, bus_cyc, 1'b0);
        chk1({tag, " idle iresp"}, ifetch_resp, 1'b0);
        chk1({tag, " idle mresp"}, mem_resp, 1'b0);
        step;
        for (int i = 0; i <= k; i++) begin
            bus_ack   = (i == k);
            bus_dat_r = datr;
            @(negedge clk);
            chk1({tag, " cyc"}, bus_cyc, 1'b1);
            chk1({tag, " stb"}, bus_stb, 1'b1);
            chkv({tag, " adr"}, LINE_W'(bus_adr), LINE_W'(adr));
            chk1({tag, " we"}, bus_we, we);
            chkv({tag, " sel"}, LINE_W'(bus_sel), LINE_W'(sel));
            if (we) chkv({tag, " dat_w"}, bus_dat_w, datw);
            chk1({tag, " early resp"}, ifetch_resp | mem_resp, 1'b0);
            step;
        end
        bus_ack = 1'b0;
        @(negedge clk);
        chk1({tag, " iresp"}, ifetch_resp, exp_i);
        chk1({tag, " mresp"}, mem_resp, !exp_i);
        chk1({tag, " resp cyc"}, bus_cyc, 1'b0);
        if (exp_i) chkv({tag, " irdata"}, ifetch_rdata, exp_rdata);
        else       chkv({tag, " mrdata"}, mem_rdata, exp_rdata);
        step;
    endtask

    initial begin
        rst_n = 1'b0; ifetch_read = 1'b0; ifetch_address = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        mem_wdata = '0; mem_sel = '0; bus_dat_r = '0; bus_ack = 1'b0;

        // Reset state
        step; step;
        @(negedge clk);
        chk1("rst cyc", bus_cyc, 1'b0);
        chk1("rst stb", bus_stb, 1'b0);
        chk1("rst we", bus_we, 1'b0);
        chkv("rst adr", LINE_W'(bus_adr), '0);
        chkv("rst sel", LINE_W'(bus_sel), '0);
        chkv("rst dat_w", bus_dat_w, '0);
        chk1("rst iresp", ifetch_resp, 1'b0);
        chk1("rst mresp", mem_resp, 1'b0);
        chkv("rst irdata", ifetch_rdata, '0);
        chkv("rst mrdata", mem_rdata, '0);
        step;
        rst_n = 1'b1;

        // 1: ifetch read, ack in first strobe cycle
        ifetch_read = 1'b1; ifetch_address = 12'h010;
        txn("T1 ifetch", 0, 1'b1, 12'h010, 1'b0, 16'hFFFF, '0,
            128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5,
            128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5);
        ifetch_read = 1'b0;

        // 2: data write, ack after 4 wait cycles; mem_rdata must stay 0
        mem_write = 1'b1; mem_address = 12'h020; mem_sel = 16'h0003;
        mem_wdata = 128'hBEEF;
        txn("T2 write", 4, 1'b0, 12'h020, 1'b1, 16'h0003, 128'hBEEF,
            128'hDEAD_0000_DEAD, 128'h0);
        mem_write = 1'b0;
        @(negedge clk);
        chk1("T2 single resp", mem_resp, 1'b0);
        step;

        // 3: both ports held from reset -> I, D, I, D
        rst_n = 1'b0;
        step; step;
        rst_n = 1'b1;
        ifetch_read = 1'b1; ifetch_address = 12'h100;
        mem_read = 1'b1; mem_address = 12'h200;
        txn("T3 g0 I", 0, 1'b1, 12'h100, 1'b0, 16'hFFFF, '0, 128'hA1, 128'hA1);
        txn("T3 g1 D", 2, 1'b0, 12'h200, 1'b0, 16'hFFFF, '0, 128'hD1, 128'hD1);
        txn("T3 g2 I", 1, 1'b1, 12'h100, 1'b0, 16'hFFFF, '0, 128'hA2, 128'hA2);
        txn("T3 g3 D", 3, 1'b0, 12'h200, 1'b0, 16'hFFFF, '0, 128'hD2, 128'hD2);
        ifetch_read = 1'b0; mem_read = 1'b0;
        chkv("T3 irdata held", ifetch_rdata, 128'hA2);

        // 4: data read kept high, address retargeted after resp
        mem_read = 1'b1; mem_address = 12'h7FF;
        txn("T4 rd0", 1, 1'b0, 12'h7FF, 1'b0, 16'hFFFF, '0, 128'h7FF7FF, 128'h7FF7FF);
        mem_address = 12'h123;
        txn("T4 rd1", 0, 1'b0, 12'h123, 1'b0, 16'hFFFF, '0, 128'h123123, 128'h123123);
        mem_read = 1'b0;
        chkv("T4 irdata untouched", ifetch_rdata, 128'hA2);

        // 5: reset while in BUS_D, ack arrives one cycle late
        mem_read = 1'b1; mem_address = 12'h055;
        @(negedge clk);
        chk1("T5 idle cyc", bus_cyc, 1'b0);
        step;
        @(negedge clk);
        chk1("T5 bus cyc", bus_cyc, 1'b1);
        rst_n = 1'b0;
        step;
        rst_n = 1'b1; mem_read = 1'b0;
        bus_ack = 1'b1; bus_dat_r = {LINE_W{1'b1}};
        @(negedge clk);
        chk1("T5 cyc", bus_cyc, 1'b0);
        chk1("T5 stb", bus_stb, 1'b0);
        chk1("T5 mresp", mem_resp, 1'b0);
        chk1("T5 iresp", ifetch_resp, 1'b0);
        chk1("T5 we", bus_we, 1'b0);
        chkv("T5 adr", LINE_W'(bus_adr), '0);
        chkv("T5 sel", LINE_W'(bus_sel), '0);
        chkv("T5 mrdata", mem_rdata, '0);
        chkv("T5 irdata", ifetch_rdata, '0);
        step;
        bus_ack = 1'b0;
        @(negedge clk);
        chk1("T5 late mresp", mem_resp, 1'b0);
        chk1("T5 late cyc", bus_cyc, 1'b0);
        chkv("T5 late mrdata", mem_rdata, '0);
        step;

        // 6: read and write both asserted -> write
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 12'h040;
        mem_sel = 16'hF0F0; mem_wdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        txn("T6 rw", 1, 1'b0, 12'h040, 1'b1, 16'hF0F0,
            128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h5555, 128'h0);
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("T6 no extra resp", mem_resp | ifetch_resp, 1'b0);
            chk1("T6 no extra cyc", bus_cyc, 1'b0);
            step;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
